fifo_sync_flags: RTL
====================

# fifo_sync_flags

Parametrised synchronous FIFO. It adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, overflow/underflow pulses, and a selectable first-word-fall-through (FWFT) read mode. It is the general-purpose single-clock buffer between producer and consumer stages in the datapath. Its read/write/flag contract is a strict superset of our existing synchronous FIFO when FWFT=0.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_LEVEL, DEPTH-2, almost_full asserted when count ≥ AFULL_LEVEL (1..DEPTH)
- AEMPTY_LEVEL, 2, almost_empty asserted when count ≤ AEMPTY_LEVEL (0..DEPTH-1)

Ports (AW = clog2(DEPTH)):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cs  in  1  chip select; gates wr_en and rd_en
- flush  in  1  synchronous empty-all; independent of cs
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request (FWFT: pop/acknowledge of data_out)
- data_out  out  DATA_WIDTH  read data
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_LEVEL
- almost_empty  out  1  count ≤ AEMPTY_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Pointers: wr_ptr and rd_ptr, each AW+1 bits. Low AW bits index storage. The MSB is a wrap bit. Both increment modulo 2^(AW+1).
- count is registered. It is +1 on write only, −1 on read only, and unchanged on both or neither. It always equals wr_ptr − rd_ptr.
- Write accept: cs & wr_en & (!full | read_accept).
- Read accept: cs & rd_en & !empty.
- When full with simultaneous read and write, both are accepted and count stays DEPTH.
- When empty with simultaneous read and write, only the write is accepted, the read is rejected, and underflow pulses.
- overflow pulses for cs & wr_en & !write_accept. underflow pulses for cs & rd_en & empty. Neither pulses when cs=0.
- flush takes priority over all requests in that cycle. Pointers and count go to 0, data_out goes to 0, and no error pulses are generated.
- FWFT=0: on read accept, data_out ← mem[rd_ptr]. Otherwise data_out holds its value.
- FWFT=1: data_out = mem[rd_ptr] combinationally whenever !empty. It is 0 when empty. rd_en acknowledges the word shown.
- Flags are combinational decodes of registered count. No flag depends on same-cycle requests.

## Timing
- Reset values: pointers 0, count 0, data_out 0, empty 1, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0.
- Write → empty deasserts 1 cycle after the accepting edge.
- FWFT=0: data valid on data_out 1 cycle after the read-accept edge.
- FWFT=1: the first word is visible on data_out in the cycle after its write edge.
- Rejected requests leave all state unchanged.
- Error pulses are registered. They are high for exactly the cycle following the offending request.
- Reset asserted mid-operation returns all state to reset values immediately. Memory contents are don't-care.

## Structure
- Shared package fifo_pkg: fifo_mode_e enum (FIFO_STD, FIFO_FWFT) and a pointer-width helper constant function.
- Sub-module fifo_ram: DEPTH×DATA_WIDTH register array with synchronous write and asynchronous read. It has no reset.
- Top level holds pointers, count, flag decode, error pulses, and the FWFT/standard output mux (generate on FWFT).

## Test plan
- Reset, then idle → empty=1, almost_empty=1, count=0, data_out=0, no pulses.
- DEPTH=8, FWFT=0: write 1..8 → full=1, almost_full from count 6. Read 8 times → data_out 1..8, each one cycle after its read. Then empty=1.
- Full, write 0xAA and read in the same cycle → both accepted, count stays 8, overflow=0. Then a write alone → overflow pulse, count 8.
- Empty, read alone → underflow pulse, data_out unchanged. Empty with simultaneous read and write of 0x55 → count=1, underflow pulse.
- FWFT=1: write 0x11 → data_out=0x11 next cycle without rd_en. rd_en → empty=1, data_out=0.
- Write 5 words, assert flush together with wr_en and rd_en → count=0, empty=1, no pulses. cs=0 with wr_en/rd_en → no state change, no pulses.

Source files
------------

// File: rtl/fifo_sync_flags_pkg.sv
// +-------------------------------------------------------------------------+
// | fifo_pkg : shared types and helpers for the synchronous flag FIFO        |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Index width for a power-of-two storage depth.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync_flags_if.sv
// +-------------------------------------------------------------------------+
// | fifo_sync_flags_if : request/status bundle between producer and FIFO     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

interface fifo_sync_flags_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) ();

  localparam int AW = ptr_width(DEPTH);

  logic                  cs;
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [AW:0]           count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output cs, flush, wr_en, data_in, rd_en,
    input  data_out, empty, full, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  cs, flush, wr_en, data_in, rd_en,
    output data_out, empty, full, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/fifo_sync_flags_ram.sv
// +-------------------------------------------------------------------------+
// | fifo_ram : DEPTH x DATA_WIDTH storage, synchronous write, async read     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ptr_width(DEPTH)-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [ptr_width(DEPTH)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_sync_flags.sv
// +-------------------------------------------------------------------------+
// | fifo_sync_flags : single-clock FIFO with count, almost flags, flush,    |
// | overflow/underflow pulses and selectable FWFT read.  Rev 1.0            |
// +-------------------------------------------------------------------------+
`default_nettype none

module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_sync_flags_if.slave bus
);

  localparam int         AW     = ptr_width(DEPTH);
  localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [AW:0] FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT  = (AW + 1)'(AFULL_LEVEL);
  localparam logic [AW:0] AEMPTY_CNT = (AW + 1)'(AEMPTY_LEVEL);

  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [AW:0]           w_wr_ptr_nxt;
  logic [AW:0]           w_rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write paired with a read.
  always_comb begin
    w_rd_acc     = bus.cs & bus.rd_en & ~w_empty;
    w_wr_acc     = bus.cs & bus.wr_en & (~w_full | w_rd_acc);
    w_wr_ptr_nxt = r_wr_ptr + (AW + 1)'(w_wr_acc);
    w_rd_ptr_nxt = r_rd_ptr + (AW + 1)'(w_rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      r_overflow  <= bus.cs & bus.wr_en & ~w_wr_acc;
      r_underflow <= bus.cs & bus.rd_en & w_empty;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr_acc & ~bus.flush),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_rdata)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      assign bus.data_out = w_empty ? '0 : w_rdata;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_data_out;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data_out <= '0;
        end else if (bus.flush) begin
          r_data_out <= '0;
        end else if (w_rd_acc) begin
          r_data_out <= w_rdata;
        end
      end

      assign bus.data_out = r_data_out;
    end
  endgenerate

  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (r_count >= AFULL_CNT);
  assign bus.almost_empty = (r_count <= AEMPTY_CNT);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire
